srambank_arb2_64x4x20: RTL and testbench

Two-requester controller for one `srambank_64x4x20_6t122` instance: 256 words × 20 bits, 1-cycle synchronous read, output held until the next read.
- Runs a post-reset zero-fill of all 256 words.
- Then shares the bank between requesters A and B with round-robin arbitration and valid/ready request handshakes.
- Returns read data to the issuing requester with fixed latency.
- Sits between two client pipelines and the bank macro. It is the only driver of the bank's inputs.

---
 rtl/srambank_ctrl_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/srambank_arb2_64x4x20.sv | 143 ++++++++++++++
 tb/tb_srambank_arb2_64x4x20.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srambank_ctrl_pkg.sv
// Shared types for the two-requester SRAM bank controller: FSM states,
// requester ids and the read-return tag carried alongside each issue.
package srambank_ctrl_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 20;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

  // One entry of the return pipeline: was the issued access a read, and who asked.
  typedef struct packed {
    logic    read;
    req_id_e id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{read: 1'b0, id: REQ_A};

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a conflict
// the requester that did not win the most recent accepted grant goes first.
module rr_arb2
  import srambank_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_e last_grant;

  // One-hot grant; bit 0 is requester A, bit 1 is requester B.
  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || last_grant == REQ_B)) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

  // Remember the winner only when its request is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_B;
    end else if (accept) begin
      last_grant <= grant[1] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/srambank_arb2_64x4x20.sv
// Controller for one 256x20 SRAM bank shared by two requesters. After reset
// it optionally zero-fills the bank, then arbitrates round-robin between A
// and B, registers each accepted access onto the bank pins and returns read
// data to the issuing port two cycles after acceptance.
module srambank_arb2_64x4x20
  import srambank_ctrl_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_write,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rsp_valid,
  output logic [DW-1:0] a_rsp_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_write,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rsp_valid,
  output logic [DW-1:0] b_rsp_data,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wd,
  output logic          mem_banksel,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_dataout,
  output logic          init_done
);

  localparam logic [AW-1:0] INIT_LAST = '1;

  ctrl_state_e   state;
  logic [AW-1:0] init_cnt;
  tag_t          tag_s1;
  tag_t          tag_s2;

  logic          run_ok;
  logic [1:0]    req_valid;
  logic [1:0]    grant;
  logic          accept;
  logic          sel_b;
  req_id_e       req_id;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  // Requests are only visible to the arbiter in RUN and never while reset is held.
  assign run_ok    = (state == RUN) && !rst;
  assign req_valid = {b_valid, a_valid} & {2{run_ok}};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .accept (accept),
    .grant  (grant)
  );

  assign a_ready   = grant[0];
  assign b_ready   = grant[1];
  assign accept    = grant[0] | grant[1];
  assign sel_b     = grant[1];
  assign req_id    = sel_b ? REQ_B : REQ_A;
  assign req_write = sel_b ? b_write : a_write;
  assign req_addr  = sel_b ? b_addr  : a_addr;
  assign req_wdata = sel_b ? b_wdata : a_wdata;

  // FSM and zero-fill counter; RUN is entered on the edge that puts the last fill write on the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT_ZERO ? INIT : RUN;
      init_cnt  <= '0;
      init_done <= !INIT_ZERO;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + AW'(1);
          if (init_cnt == INIT_LAST) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  // Bank-input flops: fill writes in INIT, accepted requests in RUN, otherwise deselect and hold addr/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_address <= '0;
      mem_wd      <= '0;
      mem_banksel <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else if (state == INIT) begin
      mem_address <= init_cnt;
      mem_wd      <= '0;
      mem_banksel <= 1'b1;
      mem_read    <= 1'b0;
      mem_write   <= 1'b1;
    end else if (accept) begin
      mem_address <= req_addr;
      mem_wd      <= req_wdata;
      mem_banksel <= 1'b1;
      mem_read    <= !req_write;
      mem_write   <= req_write;
    end else begin
      mem_banksel <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end
  end

  // Return tags: stage 1 travels with the pins, stage 2 lines up with the bank's read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_s1 <= TAG_IDLE;
      tag_s2 <= TAG_IDLE;
    end else begin
      tag_s1 <= accept ? '{read: !req_write, id: req_id} : TAG_IDLE;
      tag_s2 <= tag_s1;
    end
  end

  assign a_rsp_valid = tag_s2.read && (tag_s2.id == REQ_A);
  assign b_rsp_valid = tag_s2.read && (tag_s2.id == REQ_B);
  assign a_rsp_data  = mem_dataout;
  assign b_rsp_data  = mem_dataout;

endmodule

// File: tb/tb_srambank_arb2_64x4x20.sv
// Bench for srambank_arb2_64x4x20: a behavioural bank per DUT, a scoreboard
// built from the arbitration/latency rules, and directed plus random scenarios.
module tb_srambank_arb2_64x4x20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- DUT 0 (zero-fill enabled) ----------------
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, a_write = 1'b0, b_write = 1'b0;
  logic [7:0]  a_addr = '0, b_addr = '0;
  logic [19:0] a_wdata = '0, b_wdata = '0;
  logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid;
  logic [19:0] a_rsp_data, b_rsp_data;
  logic [7:0]  mem_address;
  logic [19:0] mem_wd, mem_dataout;
  logic        mem_banksel, mem_read, mem_write, init_done;

  srambank_arb2_64x4x20 #(.AW(8), .DW(20), .INIT_ZERO(1'b1)) dut0 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .mem_address(mem_address), .mem_wd(mem_wd), .mem_banksel(mem_banksel),
    .mem_read(mem_read), .mem_write(mem_write), .mem_dataout(mem_dataout),
    .init_done(init_done)
  );

  // Bank model: 1-cycle synchronous read, output held; starts full of garbage.
  logic [19:0] bank0 [256];
  logic        seeded0 = 1'b0;
  always @(posedge clk) begin
    if (!seeded0) begin
      for (int i = 0; i < 256; i++) bank0[i] <= 20'($urandom);
      seeded0 <= 1'b1;
    end else if (mem_banksel) begin
      if (mem_write) bank0[mem_address] <= mem_wd;
      if (mem_read) mem_dataout <= bank0[mem_address];
    end
  end

  // ---------------- DUT 1 (no zero-fill) ----------------
  logic        rst_1 = 1'b1;
  logic        a_valid_1 = 1'b0, a_write_1 = 1'b0;
  logic [7:0]  a_addr_1 = '0;
  logic [19:0] a_wdata_1 = '0;
  logic        b_valid_1 = 1'b0, b_write_1 = 1'b0;
  logic [7:0]  b_addr_1 = '0;
  logic [19:0] b_wdata_1 = '0;
  logic        a_ready_1, b_ready_1, a_rsp_valid_1, b_rsp_valid_1;
  logic [19:0] a_rsp_data_1, b_rsp_data_1;
  logic [7:0]  mem_address_1;
  logic [19:0] mem_wd_1, mem_dataout_1;
  logic        mem_banksel_1, mem_read_1, mem_write_1, init_done_1;

  srambank_arb2_64x4x20 #(.AW(8), .DW(20), .INIT_ZERO(1'b0)) dut1 (
    .clk(clk), .rst(rst_1),
    .a_valid(a_valid_1), .a_ready(a_ready_1), .a_write(a_write_1), .a_addr(a_addr_1), .a_wdata(a_wdata_1),
    .a_rsp_valid(a_rsp_valid_1), .a_rsp_data(a_rsp_data_1),
    .b_valid(b_valid_1), .b_ready(b_ready_1), .b_write(b_write_1), .b_addr(b_addr_1), .b_wdata(b_wdata_1),
    .b_rsp_valid(b_rsp_valid_1), .b_rsp_data(b_rsp_data_1),
    .mem_address(mem_address_1), .mem_wd(mem_wd_1), .mem_banksel(mem_banksel_1),
    .mem_read(mem_read_1), .mem_write(mem_write_1), .mem_dataout(mem_dataout_1),
    .init_done(init_done_1)
  );

  logic [19:0] bank1 [256];
  always @(posedge clk) begin
    if (mem_banksel_1) begin
      if (mem_write_1) bank1[mem_address_1] <= mem_wd_1;
      if (mem_read_1) mem_dataout_1 <= bank1[mem_address_1];
    end
  end

  // ---------------- reference model for DUT 0 ----------------
  int cyc = 0;
  int rel_cnt = 0;   // cycles since reset release; fill write k is on the pins when rel_cnt == k+1
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (rst) rel_cnt <= 0;
    else if (rel_cnt < 1000000) rel_cnt <= rel_cnt + 1;
  end

  typedef struct {
    logic        is_b;
    logic [19:0] data;
    int          due;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [19:0] ref_mem [256];
  logic        m_last_b = 1'b1;
  logic        pa_acc = 1'b0;
  logic        pa_wr = 1'b0;
  logic [7:0]  pa_addr = '0;
  logic [19:0] pa_wd = '0;

  always @(negedge clk) begin : scoreboard
    logic        ev_a, ev_b, ga, gb;
    logic [19:0] ed;
    rsp_t        e;
    if (rst) begin
      exp_q.delete();
      m_last_b = 1'b1;
      pa_acc   = 1'b0;
    end else begin
      if (rel_cnt == 256) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      end
      n_cmp++;
      if (mem_read && mem_write) begin
        n_err++;
        $display("FAIL rw_exclusive cycle %0d: read=%b write=%b, required not both 1", cyc, mem_read, mem_write);
      end
      ev_a = 1'b0; ev_b = 1'b0; ed = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (e.is_b) ev_b = 1'b1; else ev_a = 1'b1;
        ed = e.data;
      end
      n_cmp++;
      if ({a_rsp_valid, b_rsp_valid} !== {ev_a, ev_b}) begin
        n_err++;
        $display("FAIL rsp_valid cycle %0d: got a=%b b=%b, required a=%b b=%b", cyc, a_rsp_valid, b_rsp_valid, ev_a, ev_b);
      end
      if (ev_a) begin
        n_cmp++;
        if (a_rsp_data !== ed) begin
          n_err++;
          $display("FAIL a_rsp_data cycle %0d: got %h, required %h", cyc, a_rsp_data, ed);
        end
      end
      if (ev_b) begin
        n_cmp++;
        if (b_rsp_data !== ed) begin
          n_err++;
          $display("FAIL b_rsp_data cycle %0d: got %h, required %h", cyc, b_rsp_data, ed);
        end
      end
      if (pa_acc) begin
        n_cmp++;
        if ({mem_banksel, mem_write, mem_read, mem_address} !== {1'b1, pa_wr, !pa_wr, pa_addr} ||
            (pa_wr && mem_wd !== pa_wd)) begin
          n_err++;
          $display("FAIL issue_pins cycle %0d: got sel=%b w=%b r=%b addr=%h wd=%h, required w=%b addr=%h wd=%h",
                   cyc, mem_banksel, mem_write, mem_read, mem_address, mem_wd, pa_wr, pa_addr, pa_wd);
        end
      end else if (rel_cnt > 256) begin
        n_cmp++;
        if ({mem_banksel, mem_read, mem_write} !== 3'b000) begin
          n_err++;
          $display("FAIL idle_pins cycle %0d: got sel=%b r=%b w=%b, required 000", cyc, mem_banksel, mem_read, mem_write);
        end
      end
      ga = 1'b0; gb = 1'b0;
      if (rel_cnt >= 256) begin
        ga = a_valid && (!b_valid || m_last_b);
        gb = b_valid && !ga;
      end
      n_cmp++;
      if ({a_ready, b_ready} !== {ga, gb}) begin
        n_err++;
        $display("FAIL grant cycle %0d: got a_ready=%b b_ready=%b, required %b %b", cyc, a_ready, b_ready, ga, gb);
      end
      pa_acc = ga || gb;
      if (pa_acc) begin
        pa_wr   = gb ? b_write : a_write;
        pa_addr = gb ? b_addr  : a_addr;
        pa_wd   = gb ? b_wdata : a_wdata;
        if (pa_wr) begin
          ref_mem[pa_addr] = pa_wd;
        end else begin
          e.is_b = gb;
          e.data = ref_mem[pa_addr];
          e.due  = cyc + 2;
          exp_q.push_back(e);
        end
        m_last_b = gb;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic w, input logic [7:0] ad, input logic [19:0] d);
    a_valid = v; a_write = w; a_addr = ad; a_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic w, input logic [7:0] ad, input logic [19:0] d);
    b_valid = v; b_write = w; b_addr = ad; b_wdata = d;
  endtask

  task automatic idle();
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({a_ready, b_ready, a_rsp_valid, b_rsp_valid, mem_banksel, mem_read, mem_write, init_done} !== 8'b0 ||
        mem_address !== 8'h00 || mem_wd !== 20'h0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b%b rsp=%b%b sel=%b r=%b w=%b done=%b addr=%h wd=%h, required all 0",
               a_ready, b_ready, a_rsp_valid, b_rsp_valid, mem_banksel, mem_read, mem_write, init_done, mem_address, mem_wd);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (mem_banksel !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0 ||
          mem_address !== 8'(k) || mem_wd !== 20'h0 || init_done !== (k == 255)) begin
        n_err++;
        $display("FAIL init_write %0d: sel=%b w=%b r=%b addr=%h wd=%h done=%b, required 1 1 0 %h 00000 %b",
                 k, mem_banksel, mem_write, mem_read, mem_address, mem_wd, init_done, 8'(k), (k == 255));
      end
    end
    tick();
    set_a(1'b1, 1'b0, 8'h37, 20'h0);
    @(negedge clk);
    n_cmp++;
    if (a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL first_read_ready: got %b, required 1", a_ready);
    end
    tick();
    idle();
    tick();
    @(negedge clk);
    n_cmp++;
    if (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b0 || a_rsp_data !== 20'h00000) begin
      n_err++;
      $display("FAIL first_read_rsp: a_v=%b b_v=%b data=%h, required 1 0 00000", a_rsp_valid, b_rsp_valid, a_rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    set_a(1'b1, 1'b1, 8'h12, 20'hABCDE);
    tick();
    set_a(1'b1, 1'b0, 8'h12, 20'h0);
    tick();
    idle();
    tick();
    @(negedge clk);
    n_cmp++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 20'hABCDE) begin
      n_err++;
      $display("FAIL hazard_read: a_v=%b data=%h, required 1 abcde", a_rsp_valid, a_rsp_data);
    end
  endtask

  task automatic test_simultaneous_reads();
    tick();
    set_a(1'b1, 1'b1, 8'h01, 20'h11111);
    tick();
    idle();
    set_b(1'b1, 1'b1, 8'h02, 20'h22222);
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i < 8) begin
        set_a(1'b1, 1'b0, 8'h01, 20'h0);
        set_b(1'b1, 1'b0, 8'h02, 20'h0);
      end else begin
        idle();
      end
      @(negedge clk);
      if (i < 8) begin
        n_cmp++;
        if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_err++;
          $display("FAIL alternate_grant %0d: got a=%b b=%b, required %s", i, a_ready, b_ready, (i % 2 == 0) ? "A" : "B");
        end
      end
      if (i >= 2) begin
        n_cmp++;
        if ((i % 2 == 0) ? (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b0 || a_rsp_data !== 20'h11111)
                         : (b_rsp_valid !== 1'b1 || a_rsp_valid !== 1'b0 || b_rsp_data !== 20'h22222)) begin
          n_err++;
          $display("FAIL alternate_rsp %0d: a_v=%b a_d=%h b_v=%b b_d=%h, required port %s data %s",
                   i, a_rsp_valid, a_rsp_data, b_rsp_valid, b_rsp_data,
                   (i % 2 == 0) ? "A" : "B", (i % 2 == 0) ? "11111" : "22222");
        end
      end
    end
  endtask

  task automatic test_idle_gap();
    tick();
    set_b(1'b1, 1'b1, 8'hFF, 20'hFFFFF);
    @(negedge clk);
    n_cmp++;
    if (b_ready !== 1'b1) begin
      n_err++;
      $display("FAIL gap_write_ready: got %b, required 1", b_ready);
    end
    tick();
    idle();
    for (int g = 0; g < 2; g++) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if (mem_banksel !== 1'b0) begin
        n_err++;
        $display("FAIL gap_banksel %0d: got %b, required 0", g, mem_banksel);
      end
    end
    tick();
    set_b(1'b1, 1'b0, 8'hFF, 20'h0);
    @(negedge clk);
    n_cmp++;
    if (mem_banksel !== 1'b0 || b_ready !== 1'b1) begin
      n_err++;
      $display("FAIL gap_read_issue: sel=%b b_ready=%b, required 0 1", mem_banksel, b_ready);
    end
    tick();
    idle();
    tick();
    @(negedge clk);
    n_cmp++;
    if (b_rsp_valid !== 1'b1 || a_rsp_valid !== 1'b0 || b_rsp_data !== 20'hFFFFF) begin
      n_err++;
      $display("FAIL gap_read_rsp: b_v=%b a_v=%b data=%h, required 1 0 fffff", b_rsp_valid, a_rsp_valid, b_rsp_data);
    end
  endtask

  task automatic test_random();
    logic acc_a = 1'b1;
    logic acc_b = 1'b1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (acc_a) begin
        if ($urandom_range(0, 9) < 6)
          set_a(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 20'($urandom));
        else
          a_valid = 1'b0;
      end
      if (acc_b) begin
        if ($urandom_range(0, 9) < 6)
          set_b(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 20'($urandom));
        else
          b_valid = 1'b0;
      end
      @(negedge clk);
      acc_a = !a_valid || a_ready;
      acc_b = !b_valid || b_ready;
    end
    tick();
    idle();
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    tick();
    set_a(1'b1, 1'b0, 8'h03, 20'h0);
    tick();
    idle();
    set_b(1'b1, 1'b0, 8'h04, 20'h0);
    tick();
    idle();
    rst = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      n_cmp++;
      if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0 || init_done !== 1'b0 || mem_banksel !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_hold %0d: a_v=%b b_v=%b done=%b sel=%b, required 0 0 0 0",
                 r, a_rsp_valid, b_rsp_valid, init_done, mem_banksel);
      end
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (mem_address !== 8'(k) || mem_write !== 1'b1 || mem_banksel !== 1'b1 ||
          a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0 || init_done !== 1'b0) begin
        n_err++;
        $display("FAIL refill_start %0d: addr=%h w=%b sel=%b rsp=%b%b done=%b, required %h 1 1 00 0",
                 k, mem_address, mem_write, mem_banksel, a_rsp_valid, b_rsp_valid, init_done, 8'(k));
      end
    end
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (init_done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || mem_address !== 8'hFF) begin
      n_err++;
      $display("FAIL refill_done: seen=%b addr=%h, required 1 ff", seen, mem_address);
    end
    tick();
    set_a(1'b1, 1'b0, 8'h03, 20'h0);
    tick();
    idle();
    tick();
    @(negedge clk);
    n_cmp++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 20'h0) begin
      n_err++;
      $display("FAIL refill_read: a_v=%b data=%h, required 1 00000", a_rsp_valid, a_rsp_data);
    end
  endtask

  task automatic test_no_init();
    logic [19:0] val;
    val = 20'($urandom);
    tick();
    @(negedge clk);
    n_cmp++;
    if (init_done_1 !== 1'b1 || a_ready_1 !== 1'b0 || mem_banksel_1 !== 1'b0 || a_rsp_valid_1 !== 1'b0) begin
      n_err++;
      $display("FAIL noinit_reset: done=%b rdy=%b sel=%b rsp=%b, required 1 0 0 0",
               init_done_1, a_ready_1, mem_banksel_1, a_rsp_valid_1);
    end
    tick();
    rst_1 = 1'b0;
    a_valid_1 = 1'b1; a_write_1 = 1'b1; a_addr_1 = 8'h80; a_wdata_1 = val;
    @(negedge clk);
    n_cmp++;
    if (a_ready_1 !== 1'b1) begin
      n_err++;
      $display("FAIL noinit_ready_first: got %b, required 1", a_ready_1);
    end
    tick();
    a_write_1 = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (a_ready_1 !== 1'b1 || mem_write_1 !== 1'b1 || mem_address_1 !== 8'h80) begin
      n_err++;
      $display("FAIL noinit_write_issue: rdy=%b w=%b addr=%h, required 1 1 80", a_ready_1, mem_write_1, mem_address_1);
    end
    tick();
    a_valid_1 = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (a_rsp_valid_1 !== 1'b1 || b_rsp_valid_1 !== 1'b0 || a_rsp_data_1 !== val) begin
      n_err++;
      $display("FAIL noinit_read: a_v=%b b_v=%b data=%h, required 1 0 %h", a_rsp_valid_1, b_rsp_valid_1, a_rsp_data_1, val);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_simultaneous_reads();
    test_idle_gap();
    test_random();
    test_reset_mid();
    test_no_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
